// File: rtl/div_unit.sv
// Radix-2 restoring integer divider for MIPS DIV/DIVU: one quotient bit per clock, remainder on result_hi, quotient on result_lo.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  annul,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic [DATA_WIDTH-1:0] result_lo
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dsr_q;
  logic                  q_neg;
  logic                  r_neg;

  logic                  accept;
  logic                  neg_1, neg_2;
  logic [DATA_WIDTH-1:0] abs_1, abs_2;
  logic                  div_zero;
  logic                  early;
  logic                  last_iter;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] dvd_next;
  logic [DATA_WIDTH-1:0] q_fix;
  logic [DATA_WIDTH-1:0] r_fix;

  // Operand conditioning, one restoring step, and final sign correction.
  always_comb begin
    accept    = start && !annul && (state == IDLE || state == DONE);
    neg_1     = signed_div & operand_1[DATA_WIDTH-1];
    neg_2     = signed_div & operand_2[DATA_WIDTH-1];
    abs_1     = neg_1 ? -operand_1 : operand_1;
    abs_2     = neg_2 ? -operand_2 : operand_2;
    div_zero  = (operand_2 == '0);
`ifdef DIV_EARLY_OUT_EN
    early     = !div_zero && (abs_1 < abs_2);
`else
    early     = 1'b0;
`endif
    last_iter = (count == CNT_W'(DATA_WIDTH - 1));
    shifted   = {rem_q, dvd_q[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, dsr_q};
    rem_next  = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    dvd_next  = {dvd_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    q_fix     = q_neg ? -dvd_next : dvd_next;
    r_fix     = r_neg ? -rem_next : rem_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept)
          state_next = (div_zero || early) ? DONE : RUN;
        else
          state_next = IDLE;
      end
      RUN: begin
        if (last_iter)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (annul)
      state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Annul freezes the datapath so the previous results stay visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (!annul) begin
      if (accept) begin
        if (div_zero) begin
          result_lo <= '1;
          result_hi <= operand_1;
        end else if (early) begin
          result_lo <= '0;
          result_hi <= operand_1;
        end else begin
          count <= '0;
          rem_q <= '0;
          dvd_q <= abs_1;
          dsr_q <= abs_2;
          q_neg <= neg_1 ^ neg_2;
          r_neg <= neg_1;
        end
      end else if (state == RUN) begin
        rem_q <= rem_next;
        dvd_q <= dvd_next;
        count <= count + CNT_W'(1);
        if (last_iter) begin
          result_lo <= q_fix;
          result_hi <= r_fix;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: expected results from plain SV arithmetic, checked by an independent monitor on done.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic        annul = 1'b0;
  logic        busy, done;
  logic [31:0] result_hi, result_lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t sb[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .operand_1(operand_1), .operand_2(operand_2), .annul(annul),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: MIPS semantics via truncating SV division; edges after acceptance until done.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    logic signed [31:0] sa, sb_;
    logic [31:0] ma, mb;
    sa = a;
    sb_ = b;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    lat = 32;
    if (b == 0) begin
      lo = '1; hi = a; lat = 0;
    end else if (!sgn) begin
      lo = a / b; hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000; hi = 0;
    end else begin
      lo = sa / sb_; hi = sa % sb_;
    end
`ifdef DIV_EARLY_OUT_EN
    if (b != 0 && ma < mb) lat = 0;
`else
    if (ma == mb) lat = lat;
`endif
  endtask

  // Caller is at a negedge with the DUT in IDLE or DONE.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn, output int lat);
    exp_t e;
    model(a, b, sgn, e.hi, e.lo, lat);
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
    operand_1 = a; operand_2 = b; signed_div = sgn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issueUnchecked(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    operand_1 = a; operand_2 = b; signed_div = sgn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain(input int exp_busy, input bit check_busy, input string name);
    int nbusy = 0;
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) begin ok = 1; break; end
      if (busy) nbusy++;
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL %s drain: got %0d pending expected 0", name, sb.size());
    end else if (check_busy) begin
      checkOutput({name, " busy cycles"}, nbusy, exp_busy);
    end
  endtask

  task automatic checkQuiet(input int n, input string name);
    int nbusy = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    checkOutput({name, " busy cycles"}, nbusy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result_hi", result_hi, e.hi);
        checkOutput("result_lo", result_lo, e.lo);
        checkOutput("done cycle", cyc, e.due);
      end
    end
  end

  initial begin
    int lat;
    logic [31:0] a, b;
    logic sgn;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'b0, busy}, 0);
    checkOutput("reset done", {31'b0, done}, 0);
    checkOutput("reset hi", result_hi, 0);
    checkOutput("reset lo", result_lo, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(32'd100, 32'd7, 1'b0, lat);
    waitDrain(lat, 1, "divu 100/7");
    applyStimulus(32'hFFFF_FF9C, 32'd7, 1'b1, lat);
    waitDrain(lat, 1, "div -100/7");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    waitDrain(lat, 1, "div overflow");
    applyStimulus(32'h1234_5678, 32'd0, 1'b0, lat);
    waitDrain(lat, 1, "divu by zero");
    applyStimulus(32'd3, 32'd9, 1'b0, lat);
    waitDrain(lat, 1, "divu 3/9");

    // Annul mid-run with a simultaneous start: both must vanish.
    issueUnchecked(32'd50, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    operand_1 = 32'd7; operand_2 = 32'd1; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    checkOutput("annul busy", {31'b0, busy}, 0);
    checkOutput("annul done", {31'b0, done}, 0);
    checkOutput("annul hi held", result_hi, last_hi);
    checkOutput("annul lo held", result_lo, last_lo);
    checkQuiet(40, "after annul");
    checkOutput("annul hi still held", result_hi, last_hi);

    // Back-to-back start on the done cycle, then a stray start mid-run.
    applyStimulus(32'd1000, 32'd10, 1'b0, lat);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    checkOutput("b2b first done seen", {31'b0, done}, 1);
    applyStimulus(32'd20, 32'd3, 1'b0, lat);
    repeat (5) @(negedge clk);
    issueUnchecked(32'd999, 32'd1, 1'b0);
    waitDrain(0, 0, "b2b 20/3");

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      sgn = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: b = 0;
        1, 2: b = $urandom_range(1, 20);
        3: a = $urandom_range(0, 50);
        4: b = sgn ? -$urandom_range(1, 20) : b;
        default: ;
      endcase
      applyStimulus(a, b, sgn, lat);
      waitDrain(lat, 1, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a run.
    issueUnchecked(32'd77, 32'd3, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid rst busy", {31'b0, busy}, 0);
    checkOutput("mid rst done", {31'b0, done}, 0);
    checkOutput("mid rst hi", result_hi, 0);
    checkOutput("mid rst lo", result_lo, 0);
    checkQuiet(40, "after reset");

    checkOutput("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
